// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencing and IF/ID pipeline register with static beq redirect and flush recovery.
// Optional branch statistics counters are built when FETCH_BR_STATS_EN is defined.
module fetch_pc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_IF,
  input  logic        br_prediction,
  input  logic        flush,
  input  logic        branch_hazard_stall,
  input  logic        load_use_stall,
  output logic [31:0] pc_IF,
  output logic [4:0]  branch_addr_lw_5b,
  output logic [31:0] IFID_instr,
  output logic [31:0] IFID_pc_plus4,
  output logic        IFID_valid,
  output logic [5:0]  opcode_IF
`ifdef FETCH_BR_STATS_EN
  ,
  output logic [15:0] stat_br_taken_pred,
  output logic [15:0] stat_br_flush
`endif
);

  localparam logic [5:0] OP_BEQ = 6'b000100;

  logic [31:0] pc_r, ifid_instr_r, ifid_pc_plus4_r, ifid_alt_pc_r;
  logic        ifid_valid_r;
  logic [31:0] pc_d_s, ifid_instr_d_s, ifid_pc_plus4_d_s, ifid_alt_pc_d_s;
  logic        ifid_valid_d_s;
  logic        is_beq_s, taken_s, stall_s;
  logic [31:0] pc_plus4_s, target_s, alt_pc_s;

  assign is_beq_s   = (instr_IF[31:26] == OP_BEQ);
  assign taken_s    = is_beq_s & br_prediction;
  assign stall_s    = branch_hazard_stall | load_use_stall;
  assign pc_plus4_s = pc_r + 32'd4;
  assign target_s   = pc_plus4_s + {{14{instr_IF[15]}}, instr_IF[15:0], 2'b00};
  // Recovery address for ID: the path the prediction did not take.
  assign alt_pc_s   = (is_beq_s && !br_prediction) ? target_s : pc_plus4_s;

  // Next-state selection: flush, then stall, then predicted redirect, then sequential.
  always_comb begin
    pc_d_s            = pc_r;
    ifid_instr_d_s    = ifid_instr_r;
    ifid_pc_plus4_d_s = ifid_pc_plus4_r;
    ifid_alt_pc_d_s   = ifid_alt_pc_r;
    ifid_valid_d_s    = ifid_valid_r;
    if (flush) begin
      // Bubble behaves like a nop at address 0, so a repeated flush lands on 4.
      pc_d_s            = ifid_alt_pc_r;
      ifid_instr_d_s    = 32'd0;
      ifid_pc_plus4_d_s = 32'd4;
      ifid_alt_pc_d_s   = 32'd4;
      ifid_valid_d_s    = 1'b0;
    end else if (stall_s) begin
      pc_d_s = pc_r;
    end else begin
      pc_d_s            = taken_s ? target_s : pc_plus4_s;
      ifid_instr_d_s    = instr_IF;
      ifid_pc_plus4_d_s = pc_plus4_s;
      ifid_alt_pc_d_s   = alt_pc_s;
      ifid_valid_d_s    = 1'b1;
    end
  end

  // PC and IF/ID register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r            <= 32'd0;
      ifid_instr_r    <= 32'd0;
      ifid_pc_plus4_r <= 32'd0;
      ifid_alt_pc_r   <= 32'd0;
      ifid_valid_r    <= 1'b0;
    end else begin
      pc_r            <= pc_d_s;
      ifid_instr_r    <= ifid_instr_d_s;
      ifid_pc_plus4_r <= ifid_pc_plus4_d_s;
      ifid_alt_pc_r   <= ifid_alt_pc_d_s;
      ifid_valid_r    <= ifid_valid_d_s;
    end
  end

  assign pc_IF             = pc_r;
  assign branch_addr_lw_5b = pc_r[6:2];
  assign IFID_instr        = ifid_instr_r;
  assign IFID_pc_plus4     = ifid_pc_plus4_r;
  assign IFID_valid        = ifid_valid_r;
  assign opcode_IF         = instr_IF[31:26];

`ifdef FETCH_BR_STATS_EN
  logic [15:0] stat_taken_r, stat_flush_r;

  // Saturating statistics counters; a taken prediction counts only when it actually redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_taken_r <= 16'd0;
      stat_flush_r <= 16'd0;
    end else begin
      if (taken_s && !stall_s && !flush && (stat_taken_r != 16'hFFFF)) begin
        stat_taken_r <= stat_taken_r + 16'd1;
      end else begin
        stat_taken_r <= stat_taken_r;
      end
      if (flush && (stat_flush_r != 16'hFFFF)) begin
        stat_flush_r <= stat_flush_r + 16'd1;
      end else begin
        stat_flush_r <= stat_flush_r;
      end
    end
  end

  assign stat_br_taken_pred = stat_taken_r;
  assign stat_br_flush      = stat_flush_r;
`endif

endmodule
